// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared constants and types for the MEM-stage access unit:
//           control-bit indices, access-size and FSM encodings.
// Revision: 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Default widths
    localparam int DEF_NB_DATA = 32;
    localparam int DEF_NB_REG  = 5;

    // mem_signals bit indices
    localparam int MEM_SIGN  = 5;
    localparam int MEM_READ  = 4;
    localparam int MEM_WRITE = 3;
    localparam int MEM_WORD  = 2;
    localparam int MEM_HALF  = 1;
    localparam int MEM_BYTE  = 0;

    // wb_signals bit indices
    localparam int WB_REGWRITE  = 2;
    localparam int WB_MEMTOREG1 = 1;
    localparam int WB_MEMTOREG0 = 0;

    // Access size as decoded from the one-hot size bits
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Access FSM encoding
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/load_formatter.sv
`default_nettype none
// ============================================================================
// Module  : load_formatter
// Brief   : Picks the addressed byte/halfword lane out of a little-endian
//           read word and sign- or zero-extends it to the datapath width.
// Revision: 1.0 - initial release
// ============================================================================
module load_formatter
    import mips_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA
) (
    input  logic [NB_DATA-1:0] rdata_i,
    input  logic [1:0]         addr_i,
    input  size_t              size_i,
    input  logic               sign_i,
    output logic [NB_DATA-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension according to size and sign
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        data_o   = '0;

        case (addr_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase

        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            SZ_BYTE: data_o = sign_i ? {{(NB_DATA-8){byte_sel[7]}}, byte_sel}
                                     : {{(NB_DATA-8){1'b0}}, byte_sel};
            SZ_HALF: data_o = sign_i ? {{(NB_DATA-16){half_sel[15]}}, half_sel}
                                     : {{(NB_DATA-16){1'b0}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule : load_formatter
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit
// Brief   : MEM pipeline stage. Issues aligned loads/stores to a handshaked
//           data memory, stalls upstream while waiting for the ack, formats
//           load data and drives the MEM/WB register. Misaligned accesses
//           are dropped (regWrite cleared) and flagged for one cycle.
// Revision: 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int NB_DATA   = DEF_NB_DATA,
    parameter int NB_REG    = DEF_NB_REG,
    parameter int NB_MEMSIG = 6,
    parameter int NB_WBSIG  = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic [NB_MEMSIG-1:0] mem_signals_i,
    input  logic [NB_WBSIG-1:0]  wb_signals_i,
    input  logic [NB_DATA-1:0]   alu_result_i,
    input  logic [NB_DATA-1:0]   store_data_i,
    input  logic [NB_REG-1:0]    rd_i,
    output logic                 stall_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [NB_DATA-1:0]   dmem_addr_o,
    output logic [NB_DATA-1:0]   dmem_wdata_o,
    output logic [3:0]           dmem_be_o,
    input  logic [NB_DATA-1:0]   dmem_rdata_i,
    input  logic                 dmem_ack_i,
    output logic                 wb_valid_o,
    output logic [NB_WBSIG-1:0]  wb_signals_o,
    output logic [NB_DATA-1:0]   wb_data_o,
    output logic [NB_DATA-1:0]   alu_result_o,
    output logic [NB_REG-1:0]    rd_o,
    output logic                 misaligned_o
);

    state_t               state_q;
    logic                 dmem_req_q;
    logic                 dmem_we_q;
    logic [NB_DATA-1:0]   dmem_addr_q;
    logic [NB_DATA-1:0]   dmem_wdata_q;
    logic [3:0]           dmem_be_q;
    logic                 wb_valid_q;
    logic [NB_WBSIG-1:0]  wb_signals_q;
    logic [NB_DATA-1:0]   wb_data_q;
    logic [NB_DATA-1:0]   alu_result_q;
    logic [NB_REG-1:0]    rd_q;
    logic                 misaligned_q;

    // Attributes of the access in flight, captured at start
    size_t                pend_size_q;
    logic                 pend_sign_q;
    logic                 pend_load_q;
    logic [NB_WBSIG-1:0]  pend_wbsig_q;

    size_t                size;
    logic                 aligned;
    logic                 is_mem;
    logic                 is_write;
    logic                 in_idle;
    logic                 in_wait;
    logic                 start;
    logic                 misalign;
    logic                 ack;
    logic [3:0]           be_d;
    logic [NB_DATA-1:0]   wdata_d;
    logic [NB_WBSIG-1:0]  wbsig_noreg;
    logic [NB_DATA-1:0]   load_data;

    // Decode the incoming instruction: size, alignment, lanes and start
    always_comb begin
        if (mem_signals_i[MEM_WORD])      size = SZ_WORD;
        else if (mem_signals_i[MEM_HALF]) size = SZ_HALF;
        else if (mem_signals_i[MEM_BYTE]) size = SZ_BYTE;
        else                              size = SZ_WORD;

        case (size)
            SZ_BYTE: aligned = 1'b1;
            SZ_HALF: aligned = ~alu_result_i[0];
            default: aligned = (alu_result_i[1:0] == 2'b00);
        endcase

        case (size)
            SZ_BYTE: begin
                be_d    = 4'b0001 << alu_result_i[1:0];
                wdata_d = NB_DATA'(store_data_i[7:0]) << {alu_result_i[1:0], 3'b000};
            end
            SZ_HALF: begin
                be_d    = alu_result_i[1] ? 4'b1100 : 4'b0011;
                wdata_d = NB_DATA'(store_data_i[15:0]) << {alu_result_i[1], 4'b0000};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = store_data_i;
            end
        endcase

        // Both read and write set resolves to a write
        is_write = mem_signals_i[MEM_WRITE];
        is_mem   = valid_i & (mem_signals_i[MEM_READ] | mem_signals_i[MEM_WRITE]);
        in_idle  = (state_q == S_IDLE);
        in_wait  = (state_q == S_WAIT);
        start    = in_idle & is_mem & aligned;
        misalign = in_idle & is_mem & ~aligned;
        ack      = in_wait & dmem_ack_i;

        wbsig_noreg              = wb_signals_i;
        wbsig_noreg[WB_REGWRITE] = 1'b0;
    end

    assign stall_o = start | (in_wait & ~dmem_ack_i);

    load_formatter #(
        .NB_DATA (NB_DATA)
    ) u_load_formatter (
        .rdata_i (dmem_rdata_i),
        .addr_i  (alu_result_q[1:0]),
        .size_i  (pend_size_q),
        .sign_i  (pend_sign_q),
        .data_o  (load_data)
    );

    // Access FSM with the memory-request and MEM/WB registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= 4'b0000;
            wb_valid_q   <= 1'b0;
            wb_signals_q <= '0;
            wb_data_q    <= '0;
            alu_result_q <= '0;
            rd_q         <= '0;
            misaligned_q <= 1'b0;
            pend_size_q  <= SZ_WORD;
            pend_sign_q  <= 1'b0;
            pend_load_q  <= 1'b0;
            pend_wbsig_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    misaligned_q <= misalign;
                    alu_result_q <= alu_result_i;
                    rd_q         <= rd_i;
                    wb_data_q    <= '0;
                    if (start) begin
                        state_q      <= S_WAIT;
                        dmem_req_q   <= 1'b1;
                        dmem_we_q    <= is_write;
                        dmem_addr_q  <= {alu_result_i[NB_DATA-1:2], 2'b00};
                        dmem_wdata_q <= wdata_d;
                        dmem_be_q    <= be_d;
                        pend_size_q  <= size;
                        pend_sign_q  <= mem_signals_i[MEM_SIGN];
                        pend_load_q  <= ~is_write;
                        pend_wbsig_q <= wb_signals_i;
                        // Bubble into WB until the access completes
                        wb_valid_q   <= 1'b0;
                        wb_signals_q <= '0;
                    end else begin
                        wb_valid_q   <= valid_i;
                        if (!valid_i)     wb_signals_q <= '0;
                        else if (misalign) wb_signals_q <= wbsig_noreg;
                        else              wb_signals_q <= wb_signals_i;
                    end
                end
                default: begin
                    misaligned_q <= 1'b0;
                    if (ack) begin
                        state_q      <= S_IDLE;
                        dmem_req_q   <= 1'b0;
                        wb_valid_q   <= 1'b1;
                        wb_signals_q <= pend_wbsig_q;
                        wb_data_q    <= pend_load_q ? load_data : '0;
                    end else begin
                        wb_valid_q   <= 1'b0;
                        wb_signals_q <= '0;
                    end
                end
            endcase
        end
    end

    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign dmem_be_o    = dmem_be_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_signals_o = wb_signals_q;
    assign wb_data_o    = wb_data_q;
    assign alu_result_o = alu_result_q;
    assign rd_o         = rd_q;
    assign misaligned_o = misaligned_q;

endmodule : mem_access_unit
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_unit
// Brief   : Directed self-checking bench for mem_access_unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam logic [5:0] MS_LW  = 6'b010100;
    localparam logic [5:0] MS_LB  = 6'b110001;
    localparam logic [5:0] MS_LBU = 6'b010001;
    localparam logic [5:0] MS_LH  = 6'b110010;
    localparam logic [5:0] MS_SH  = 6'b001010;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid_i = 1'b0;
    logic [5:0]  mem_signals_i = '0;
    logic [2:0]  wb_signals_i = '0;
    logic [31:0] alu_result_i = '0;
    logic [31:0] store_data_i = '0;
    logic [4:0]  rd_i = '0;
    logic [31:0] dmem_rdata_i = '0;
    logic        dmem_ack_i = 1'b0;

    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        wb_valid_o;
    logic [2:0]  wb_signals_o;
    logic [31:0] wb_data_o;
    logic [31:0] alu_result_o;
    logic [4:0]  rd_o;
    logic        misaligned_o;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_access_unit dut (
        .clock         (clock),
        .reset         (reset),
        .valid_i       (valid_i),
        .mem_signals_i (mem_signals_i),
        .wb_signals_i  (wb_signals_i),
        .alu_result_i  (alu_result_i),
        .store_data_i  (store_data_i),
        .rd_i          (rd_i),
        .stall_o       (stall_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_rdata_i  (dmem_rdata_i),
        .dmem_ack_i    (dmem_ack_i),
        .wb_valid_o    (wb_valid_o),
        .wb_signals_o  (wb_signals_o),
        .wb_data_o     (wb_data_o),
        .alu_result_o  (alu_result_o),
        .rd_o          (rd_o),
        .misaligned_o  (misaligned_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] ms, input logic [2:0] wb,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd);
        valid_i       = v;
        mem_signals_i = ms;
        wb_signals_i  = wb;
        alu_result_i  = alu;
        store_data_i  = sd;
        rd_i          = rd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   32'(dmem_req_o),   32'h0);
        chk({tag, "_we"},    32'(dmem_we_o),    32'h0);
        chk({tag, "_addr"},  dmem_addr_o,       32'h0);
        chk({tag, "_wdata"}, dmem_wdata_o,      32'h0);
        chk({tag, "_be"},    32'(dmem_be_o),    32'h0);
        chk({tag, "_wbv"},   32'(wb_valid_o),   32'h0);
        chk({tag, "_wbs"},   32'(wb_signals_o), 32'h0);
        chk({tag, "_wbd"},   wb_data_o,         32'h0);
        chk({tag, "_alu"},   alu_result_o,      32'h0);
        chk({tag, "_rd"},    32'(rd_o),         32'h0);
        chk({tag, "_mis"},   32'(misaligned_o), 32'h0);
        chk({tag, "_stall"}, 32'(stall_o),      32'h0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_all_zero("rst");
        reset = 1'b0;
        tick();

        // LW 0x10, ack one cycle after request rises
        drive(1'b1, MS_LW, 3'b101, 32'h10, 32'h0, 5'd7);
        #1 chk("lw_stall_n", 32'(stall_o), 32'h1);
        tick();
        chk("lw_req_n1",   32'(dmem_req_o),  32'h1);
        chk("lw_we",       32'(dmem_we_o),   32'h0);
        chk("lw_be",       32'(dmem_be_o),   32'hF);
        chk("lw_addr",     dmem_addr_o,      32'h10);
        chk("lw_wbv_wait", 32'(wb_valid_o),  32'h0);
        chk("lw_stall_n1", 32'(stall_o),     32'h1);
        tick();
        chk("lw_req_n2",   32'(dmem_req_o),  32'h1);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'hDEADBEEF;
        #1 chk("lw_stall_ack", 32'(stall_o), 32'h0);
        tick();
        dmem_ack_i = 1'b0;
        chk("lw_req_done", 32'(dmem_req_o),   32'h0);
        chk("lw_wbv",      32'(wb_valid_o),   32'h1);
        chk("lw_wbd",      wb_data_o,         32'hDEADBEEF);
        chk("lw_wbs",      32'(wb_signals_o), 32'h5);
        chk("lw_rd",       32'(rd_o),         32'h7);
        chk("lw_alu",      alu_result_o,      32'h10);

        // LB (signed) at 0x13, earliest ack
        drive(1'b1, MS_LB, 3'b101, 32'h13, 32'h0, 5'd3);
        tick();
        chk("lb_be",   32'(dmem_be_o), 32'h8);
        chk("lb_addr", dmem_addr_o,    32'h10);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h80FFFFFF;
        tick();
        dmem_ack_i = 1'b0;
        chk("lb_wbd", wb_data_o, 32'hFFFFFF80);

        // LBU at 0x13
        drive(1'b1, MS_LBU, 3'b101, 32'h13, 32'h0, 5'd3);
        tick();
        dmem_ack_i = 1'b1;
        tick();
        dmem_ack_i = 1'b0;
        chk("lbu_wbd", wb_data_o, 32'h00000080);

        // LH (signed) at 0x02, upper halfword
        drive(1'b1, MS_LH, 3'b101, 32'h02, 32'h0, 5'd4);
        tick();
        chk("lh_be", 32'(dmem_be_o), 32'hC);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h80010000;
        tick();
        dmem_ack_i = 1'b0;
        chk("lh_wbd", wb_data_o, 32'hFFFF8001);

        // SH at 0x22
        drive(1'b1, MS_SH, 3'b000, 32'h22, 32'h0000ABCD, 5'd0);
        tick();
        chk("sh_addr",  dmem_addr_o,       32'h20);
        chk("sh_be",    32'(dmem_be_o),    32'hC);
        chk("sh_wdata", dmem_wdata_o,      32'hABCD0000);
        chk("sh_we",    32'(dmem_we_o),    32'h1);
        chk("sh_req",   32'(dmem_req_o),   32'h1);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h12345678;
        tick();
        dmem_ack_i = 1'b0;
        chk("sh_wbv", 32'(wb_valid_o), 32'h1);
        chk("sh_wbd", wb_data_o,       32'h0);

        // Stray ack while idle
        drive(1'b0, 6'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        dmem_ack_i = 1'b1;
        tick();
        dmem_ack_i = 1'b0;
        chk("idle_ack_req",   32'(dmem_req_o),   32'h0);
        chk("idle_ack_wbv",   32'(wb_valid_o),   32'h0);
        chk("idle_ack_wbs",   32'(wb_signals_o), 32'h0);
        chk("idle_ack_stall", 32'(stall_o),      32'h0);

        // Non-memory instruction passes through
        drive(1'b1, 6'b0, 3'b100, 32'h1234, 32'h0, 5'd9);
        #1 chk("alu_stall", 32'(stall_o), 32'h0);
        tick();
        chk("alu_wbv", 32'(wb_valid_o),   32'h1);
        chk("alu_wbs", 32'(wb_signals_o), 32'h4);
        chk("alu_alu", alu_result_o,      32'h1234);
        chk("alu_rd",  32'(rd_o),         32'h9);
        chk("alu_wbd", wb_data_o,         32'h0);
        chk("alu_req", 32'(dmem_req_o),   32'h0);

        // Misaligned LW at 0x06
        drive(1'b1, MS_LW, 3'b101, 32'h06, 32'h0, 5'd5);
        #1 chk("mis_stall", 32'(stall_o), 32'h0);
        tick();
        drive(1'b0, 6'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        chk("mis_req",  32'(dmem_req_o),   32'h0);
        chk("mis_flag", 32'(misaligned_o), 32'h1);
        chk("mis_wbs",  32'(wb_signals_o), 32'h1);
        chk("mis_wbv",  32'(wb_valid_o),   32'h1);
        tick();
        chk("mis_pulse_end", 32'(misaligned_o), 32'h0);

        // LW 0x40, ack withheld, reset mid-WAIT, then a late ack
        drive(1'b1, MS_LW, 3'b101, 32'h40, 32'h0, 5'd2);
        tick();
        chk("rw_req", 32'(dmem_req_o), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rw_stall_wait", 32'(stall_o), 32'h1);
        end
        drive(1'b0, 6'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        reset = 1'b1;
        #1 chk_all_zero("rw_rst");
        tick();
        reset = 1'b0;
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'hFFFFFFFF;
        tick();
        dmem_ack_i = 1'b0;
        chk_all_zero("rw_late");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_access_unit
`default_nettype wire
